// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, word-addressed instruction memory with a load
// port, and the IF/ID pipeline register with stall and branch-flush handling.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   pc_out,
  output logic [31:0]                   instr_out,
  output logic [31:0]                   pc_plus4_out,
  output logic                          valid_out
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0]   r_mem [IMEM_DEPTH];
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc_plus4;
  logic          r_valid;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_fetch;
  logic [31:0]   w_pc_plus4;

  // Upper PC bits are dropped so addresses alias modulo the memory size.
  assign w_idx      = r_pc[AW+1:2];
  assign w_fetch    = r_mem[w_idx];
  assign w_pc_plus4 = r_pc + 32'd4;

  // Loads ignore reset/stall/branch; a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_pc_plus4;
      r_instr    <= w_fetch;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign pc_out       = r_pc;
  assign instr_out    = r_instr;
  assign pc_plus4_out = r_pc_plus4;
  assign valid_out    = r_valid;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (RESET_PC 0 and 4) share stimulus and
// are checked every cycle against a behavioural model, plus directed checks.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, load_en;
  logic [31:0] branch_target, load_data;
  logic [5:0]  load_addr;
  logic [31:0] pc_o [2];
  logic [31:0] in_o [2];
  logic [31:0] pp_o [2];
  logic        vl_o [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] mmem  [64];
  logic [31:0] mpc   [2];
  logic [31:0] minstr[2];
  logic [31:0] mpp4  [2];
  logic        mvld  [2];
  logic [31:0] rpc   [2];
  logic [31:0] nw;

  always #5 clk = ~clk;

  instr_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .pc_out(pc_o[0]), .instr_out(in_o[0]),
    .pc_plus4_out(pp_o[0]), .valid_out(vl_o[0]));

  instr_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h4)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .pc_out(pc_o[1]), .instr_out(in_o[1]),
    .pc_plus4_out(pp_o[1]), .valid_out(vl_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare both instances.
  task automatic cyc(input logic rs, input logic st, input logic br, input logic [31:0] tg,
                     input logic ld, input logic [5:0] la, input logic [31:0] dd);
    reset = rs; stall = st; branch_taken = br; branch_target = tg;
    load_en = ld; load_addr = la; load_data = dd;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        mpc[k] = rpc[k]; minstr[k] = 0; mpp4[k] = 0; mvld[k] = 0;
      end else if (br) begin
        mpc[k] = tg; minstr[k] = 0; mpp4[k] = 0; mvld[k] = 0;
      end else if (!st) begin
        minstr[k] = mmem[(mpc[k] / 4) % 64];
        mpp4[k]   = mpc[k] + 4;
        mpc[k]    = mpc[k] + 4;
        mvld[k]   = 1'b1;
      end
    end
    if (ld) mmem[la] = dd;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pc%0d", k),    pc_o[k], mpc[k]);
      chk($sformatf("instr%0d", k), in_o[k], minstr[k]);
      chk($sformatf("pp4_%0d", k),  pp_o[k], mpp4[k]);
      chk($sformatf("valid%0d", k), {31'd0, vl_o[k]}, {31'd0, mvld[k]});
    end
  endtask

  task automatic run(input logic st, input logic br, input logic [31:0] tg);
    cyc(1'b0, st, br, tg, 1'b0, 6'd0, 32'd0);
  endtask

  initial begin
    rpc[0] = 32'h0; rpc[1] = 32'h4;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Program load under reset
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: nw = 32'h2001_0005;
        1: nw = 32'h2002_0007;
        2: nw = 32'h0022_1820;
        3: nw = 32'hAC03_0000;
        default: nw = $urandom;
      endcase
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, i[5:0], nw);
    end
    chk("rst_pc_b", pc_o[1], 32'h4);
    chk("rst_valid", {31'd0, vl_o[0]}, 32'd0);

    // Sequential fetch
    run(0, 0, 0); chk("seq0", in_o[0], 32'h2001_0005); chk("seq0_pp4", pp_o[0], 32'd4);
    run(0, 0, 0); chk("seq1", in_o[0], 32'h2002_0007); chk("seq1_pp4", pp_o[0], 32'd8);
    // Stall 3 cycles
    for (int i = 0; i < 3; i++) begin
      run(1, 0, 0); chk("stall_pc", pc_o[0], 32'd8); chk("stall_in", in_o[0], 32'h2002_0007);
    end
    run(0, 0, 0); chk("post_stall", in_o[0], 32'h0022_1820); chk("post_stall_pp4", pp_o[0], 32'd12);
    run(0, 0, 0); chk("seq3", in_o[0], 32'hAC03_0000); chk("seq3_pp4", pp_o[0], 32'd16);
    // Branch wins over stall
    run(1, 1, 32'h8); chk("br_pc", pc_o[0], 32'd8); chk("br_vld", {31'd0, vl_o[0]}, 32'd0);
    run(0, 0, 0); chk("br_fetch", in_o[0], 32'h0022_1820); chk("br_vld1", {31'd0, vl_o[0]}, 32'd1);
    // Reset during stall at PC=12
    run(1, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
    chk("rst_mid_pc", pc_o[1], 32'h4); chk("rst_mid_in", in_o[1], 32'h0);
    run(0, 0, 0); chk("rst_exit_b", in_o[1], 32'h2002_0007); chk("rst_exit_a", in_o[0], 32'h2001_0005);
    // Wrap and alias
    run(0, 1, 32'hFFFF_FFFC);
    run(0, 0, 0); chk("wrap_in", in_o[0], mmem[63]); chk("wrap_pp4", pp_o[0], 32'd0);
    run(0, 0, 0); chk("wrap_next", in_o[0], 32'h2001_0005);
    run(0, 1, 32'h100);
    run(0, 0, 0); chk("alias", in_o[0], 32'h2001_0005);
    // Load/fetch collision at word 5
    nw = mmem[5];
    run(0, 1, 32'd20);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    chk("coll_old", in_o[0], nw);
    run(0, 1, 32'd20);
    run(0, 0, 0); chk("coll_new", in_o[0], 32'hDEAD_BEEF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 6'($urandom), 2'($urandom)},
          ($urandom_range(0, 3) == 0), 6'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
